// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: requests a 16-word line, latches it, then issues
// it to decode as eight even/odd pairs before fetching the next line.
module instruction_fetch #(
    parameter int unsigned LINE_WORDS = 16,
    parameter int unsigned PC_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [0:31]     instr [0:LINE_WORDS-1],
    output logic [PC_W-1:0] pc,
    output logic            read_enable,
    output logic [31:0]     ins_even,
    output logic [31:0]     ins_odd,
    output logic [PC_W-1:0] ins_pc,
    output logic            ins_valid
);

    typedef enum logic [1:0] {StIdle, StFetch, StWait, StIssue} state_e;

    state_e      state_q, state_d;
    logic [2:0]  pair_q;
    logic [0:31] buffer_q [0:LINE_WORDS-1];

    logic [2:0]  pair_nxt;
    logic [3:0]  even_idx;
    logic [3:0]  odd_idx;

    // Index of the pair issued on the next cycle of ISSUE.
    always_comb begin
        pair_nxt = pair_q + 3'd1;
        even_idx = {pair_nxt, 1'b0};
        odd_idx  = {pair_nxt, 1'b1};
    end

    // Next-state logic: fixed FETCH -> WAIT -> ISSUE(x8) loop.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  state_d = StFetch;
            StFetch: state_d = StWait;
            StWait:  state_d = StIssue;
            StIssue: if (pair_q == 3'd7) state_d = StFetch;
            default: state_d = StIdle;
        endcase
    end

    // State register, request strobe, line buffer and registered issue ports.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            pc          <= '0;
            read_enable <= 1'b0;
            ins_even    <= '0;
            ins_odd     <= '0;
            ins_pc      <= '0;
            ins_valid   <= 1'b0;
            pair_q      <= '0;
            for (int k = 0; k < LINE_WORDS; k++) begin
                buffer_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            read_enable <= (state_d == StFetch);
            unique case (state_q)
                StWait: begin
                    // instr is only sampled at the end of WAIT, never on the
                    // edge that also samples read_enable=1.
                    for (int k = 0; k < LINE_WORDS; k++) begin
                        buffer_q[k] <= instr[k];
                    end
                    // Pair 0 comes straight from the bus so it issues this edge.
                    pair_q    <= '0;
                    ins_even  <= instr[0];
                    ins_odd   <= instr[1];
                    ins_pc    <= pc;
                    ins_valid <= 1'b1;
                end
                StIssue: begin
                    if (pair_q == 3'd7) begin
                        pc        <= pc + PC_W'(LINE_WORDS);
                        ins_valid <= 1'b0;
                    end else begin
                        pair_q   <= pair_nxt;
                        ins_even <= buffer_q[even_idx];
                        ins_odd  <= buffer_q[odd_idx];
                        ins_pc   <= pc + PC_W'(even_idx);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a one-cycle-latency memory model.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [0:31] instr [0:15] = '{default: '0};
    logic [7:0]  pc;
    logic        read_enable;
    logic [31:0] ins_even;
    logic [31:0] ins_odd;
    logic [7:0]  ins_pc;
    logic        ins_valid;

    logic [31:0] key = '0;
    logic        garbage_en = 1'b0;
    int          errors = 0;
    int          checks = 0;

    instruction_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .pc          (pc),
        .read_enable (read_enable),
        .ins_even    (ins_even),
        .ins_odd     (ins_odd),
        .ins_pc      (ins_pc),
        .ins_valid   (ins_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_at(input logic [7:0] idx);
        return {24'h0, idx} ^ key;
    endfunction

    // Memory answers on the edge that samples read_enable=1; otherwise it
    // optionally scribbles on the bus so stray sampling becomes visible.
    always @(posedge clk) begin
        if (read_enable) begin
            for (int k = 0; k < 16; k++) instr[k] <= word_at(pc + 8'(k));
        end else if (garbage_en) begin
            for (int k = 0; k < 16; k++) instr[k] <= {8'hEE, 24'($urandom())};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge of a FETCH cycle; leaves at the next FETCH cycle.
    task automatic expect_line(input logic [7:0] base);
        logic [7:0] a;
        chk("fetch_re", 32'(read_enable), 32'd1);
        chk("fetch_pc", 32'(pc), 32'(base));
        chk("fetch_valid", 32'(ins_valid), 32'd0);
        @(negedge clk);
        chk("wait_re", 32'(read_enable), 32'd0);
        chk("wait_valid", 32'(ins_valid), 32'd0);
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            a = base + 8'(2 * j);
            chk("issue_valid", 32'(ins_valid), 32'd1);
            chk("issue_re", 32'(read_enable), 32'd0);
            chk("issue_even", ins_even, word_at(a));
            chk("issue_odd", ins_odd, word_at(a + 8'd1));
            chk("issue_pc", 32'(ins_pc), 32'(a));
        end
        @(negedge clk);
        chk("next_valid", 32'(ins_valid), 32'd0);
    endtask

    initial begin
        // Reset held two cycles.
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_re", 32'(read_enable), 32'd0);
        chk("rst_valid", 32'(ins_valid), 32'd0);
        chk("rst_even", ins_even, 32'd0);
        reset = 1'b0;

        // Cycle 1 after release: first request at pc=0; then sixteen lines,
        // wrapping from 240 back to 0 (requests at cycles 1, 11, 21, ...).
        @(negedge clk);
        for (int l = 0; l < 16; l++) expect_line(8'(l * 16));
        chk("wrap_pc", 32'(pc), 32'd0);
        chk("wrap_re", 32'(read_enable), 32'd1);

        // Reset asynchronously while pair 3 of the next line is on the outputs.
        @(negedge clk);
        repeat (4) @(negedge clk);
        chk("pre_rst_pc", 32'(ins_pc), 32'd6);
        chk("pre_rst_even", ins_even, 32'd6);
        #2 reset = 1'b1;
        #1;
        chk("arst_pc", 32'(pc), 32'd0);
        chk("arst_re", 32'(read_enable), 32'd0);
        chk("arst_even", ins_even, 32'd0);
        chk("arst_odd", ins_odd, 32'd0);
        chk("arst_inspc", 32'(ins_pc), 32'd0);
        chk("arst_valid", 32'(ins_valid), 32'd0);

        // New contents and garbage on the bus outside the WAIT cycle.
        key        = 32'hCAFE_0000;
        garbage_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_line(8'd0);
        expect_line(8'd16);
        chk("final_pc", 32'(pc), 32'd32);
        chk("final_re", 32'(read_enable), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
